pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, multi-cycle op and redirect handling
// with sticky timeout flag and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int MC_TIMEOUT       = 64,
    parameter int REDIRECT_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_mem_read_en,
    input  logic        ex_redirect,
    input  logic        ex_mc_start,
    input  logic        ex_mc_done,
    input  logic        cnt_clr,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_bubble,
    output logic [1:0]  state,
    output logic        mc_timeout,
    output logic [15:0] stall_cycles,
    output logic [15:0] redirect_count
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MC_WAIT  = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    localparam logic [9:0] TO_VAL = 10'(MC_TIMEOUT);
    localparam logic [2:0] RB_VAL = 3'(REDIRECT_BUBBLES);

    state_t      cur, nxt;
    logic [9:0]  wait_cnt, wait_nxt;
    logic [2:0]  bub_cnt, bub_nxt;
    logic        to_flag, to_hit, redir_acc, load_use;
    logic        pc_stall_c, if_id_stall_c, id_ex_stall_c;
    logic        if_id_flush_c, id_ex_flush_c, ex_mem_bubble_c;

    assign load_use = ex_mem_read_en && (ex_rd_addr != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                       (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

    always_comb begin
        nxt             = cur;
        wait_nxt        = wait_cnt;
        bub_nxt         = bub_cnt;
        pc_stall_c      = 1'b0;
        if_id_stall_c   = 1'b0;
        id_ex_stall_c   = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_flush_c   = 1'b0;
        ex_mem_bubble_c = 1'b0;
        to_hit          = 1'b0;
        redir_acc       = 1'b0;
        case (cur)
            S_RUN: begin
                if (ex_redirect) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    redir_acc     = 1'b1;
                    if (REDIRECT_BUBBLES > 0) begin
                        nxt     = S_REDIRECT;
                        bub_nxt = RB_VAL;
                    end
                end else if (ex_mc_start) begin
                    // a single-cycle completion needs no stall at all
                    if (!ex_mc_done) begin
                        pc_stall_c      = 1'b1;
                        if_id_stall_c   = 1'b1;
                        id_ex_stall_c   = 1'b1;
                        ex_mem_bubble_c = 1'b1;
                        nxt             = S_MC_WAIT;
                        wait_nxt        = 10'd1;
                    end
                end else if (load_use) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
            end
            S_MC_WAIT: begin
                if (ex_mc_done) begin
                    nxt      = S_RUN;
                    wait_nxt = 10'd0;
                end else if (wait_cnt == TO_VAL) begin
                    to_hit        = 1'b1;
                    id_ex_flush_c = 1'b1;
                    nxt           = S_RUN;
                    wait_nxt      = 10'd0;
                end else begin
                    pc_stall_c      = 1'b1;
                    if_id_stall_c   = 1'b1;
                    id_ex_stall_c   = 1'b1;
                    ex_mem_bubble_c = 1'b1;
                    wait_nxt        = wait_cnt + 10'd1;
                end
            end
            S_REDIRECT: begin
                if_id_flush_c = 1'b1;
                if (ex_redirect) begin
                    id_ex_flush_c = 1'b1;
                    redir_acc     = 1'b1;
                    bub_nxt       = RB_VAL;
                end else if (bub_cnt <= 3'd1) begin
                    nxt     = S_RUN;
                    bub_nxt = 3'd0;
                end else begin
                    bub_nxt = bub_cnt - 3'd1;
                end
            end
            default: nxt = S_RUN;
        endcase
    end

    // outputs are forced quiet while reset is held, whatever the inputs do
    assign pc_stall      = pc_stall_c      & ~rst;
    assign if_id_stall   = if_id_stall_c   & ~rst;
    assign id_ex_stall   = id_ex_stall_c   & ~rst;
    assign if_id_flush   = if_id_flush_c   & ~rst;
    assign id_ex_flush   = id_ex_flush_c   & ~rst;
    assign ex_mem_bubble = ex_mem_bubble_c & ~rst;
    assign state         = cur;
    assign mc_timeout    = to_flag | (to_hit & ~rst);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= S_RUN;
            wait_cnt <= 10'd0;
            bub_cnt  <= 3'd0;
            to_flag  <= 1'b0;
        end else begin
            cur      <= nxt;
            wait_cnt <= wait_nxt;
            bub_cnt  <= bub_nxt;
            if (to_hit) to_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles   <= 16'd0;
            redirect_count <= 16'd0;
        end else if (cnt_clr) begin
            stall_cycles   <= 16'd0;
            redirect_count <= 16'd0;
        end else begin
            if (pc_stall && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if (redir_acc && (redirect_count != 16'hFFFF))
                redirect_count <= redirect_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic checked
// against a behavioural reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
    localparam int RB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
    logic        id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read_en = 0;
    logic        ex_redirect = 0, ex_mc_start = 0, ex_mc_done = 0, cnt_clr = 0;
    logic        pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble;
    logic [1:0]  state;
    logic        mc_timeout;
    logic [15:0] stall_cycles, redirect_count;

    int n_pass = 0;
    int n_total = 0;

    pipe_hazard_ctrl #(.MC_TIMEOUT(TO), .REDIRECT_BUBBLES(RB)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_addr(ex_rd_addr), .ex_mem_read_en(ex_mem_read_en),
        .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .cnt_clr(cnt_clr),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
        .state(state), .mc_timeout(mc_timeout),
        .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 running, 1 waiting on the multi-cycle unit,
    // 2 draining redirect bubbles.
    int m_mode, m_waited, m_left, m_stalls, m_redirs;
    bit m_flag;
    int n_mode, n_waited, n_left, n_stalls, n_redirs;
    bit n_flag;
    bit e_pc, e_ifs, e_ids, e_iff, e_idf, e_bub, e_to;

    task automatic ref_reset();
        m_mode = 0; m_waited = 0; m_left = 0; m_stalls = 0; m_redirs = 0; m_flag = 0;
    endtask

    task automatic ref_eval();
        bit lu, took, abort;
        lu = ex_mem_read_en && ex_rd_addr != 0 &&
             ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
        {e_pc, e_ifs, e_ids, e_iff, e_idf, e_bub} = '0;
        took = 0; abort = 0;
        n_mode = m_mode; n_waited = m_waited; n_left = m_left;
        if (m_mode == 0) begin
            if (ex_redirect) begin
                e_iff = 1; e_idf = 1; took = 1;
                if (RB > 0) begin n_mode = 2; n_left = RB; end
            end else if (ex_mc_start) begin
                if (!ex_mc_done) begin
                    {e_pc, e_ifs, e_ids, e_bub} = 4'hF;
                    n_mode = 1; n_waited = 1;
                end
            end else if (lu) begin
                e_pc = 1; e_ifs = 1; e_idf = 1;
            end
        end else if (m_mode == 1) begin
            if (ex_mc_done) n_mode = 0;
            else if (m_waited == TO) begin abort = 1; e_idf = 1; n_mode = 0; end
            else begin {e_pc, e_ifs, e_ids, e_bub} = 4'hF; n_waited = m_waited + 1; end
        end else begin
            e_iff = 1;
            if (ex_redirect) begin e_idf = 1; took = 1; n_left = RB; end
            else if (m_left <= 1) n_mode = 0;
            else n_left = m_left - 1;
        end
        e_to   = m_flag | abort;
        n_flag = m_flag | abort;
        if (cnt_clr) begin
            n_stalls = 0; n_redirs = 0;
        end else begin
            n_stalls = (m_stalls + int'(e_pc) > 65535) ? 65535 : m_stalls + int'(e_pc);
            n_redirs = (m_redirs + int'(took) > 65535) ? 65535 : m_redirs + int'(took);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        m_mode = n_mode; m_waited = n_waited; m_left = n_left;
        m_stalls = n_stalls; m_redirs = n_redirs; m_flag = n_flag;
    endtask

    task automatic idle_inputs();
        id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read_en = 0;
        ex_redirect = 0; ex_mc_start = 0; ex_mc_done = 0; cnt_clr = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        ref_reset();
    endtask

    task automatic clear_counters();
        idle_inputs(); cnt_clr = 1;
        ref_eval(); advance();
        cnt_clr = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1;
        // a live load-use and mc_start must not leak through while reset is held
        ex_mem_read_en = 1; ex_rd_addr = 5'd3; id_uses_rs1 = 1; id_rs1_addr = 5'd3; ex_mc_start = 1;
        #4;
        n_total++;
        if ({pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble, state, mc_timeout} !== 9'd0)
            $display("FAIL reset_outputs: got %b expected 0",
                     {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble, state, mc_timeout});
        else n_pass++;
        n_total++;
        if ({stall_cycles, redirect_count} !== 32'd0)
            $display("FAIL reset_counters: got %h/%h expected 0/0", stall_cycles, redirect_count);
        else n_pass++;
        idle_inputs();
        @(posedge clk); #1;
        rst = 0;
        ref_reset();
    endtask

    task automatic test_load_use();
        clear_counters();
        ex_mem_read_en = 1; ex_rd_addr = 5'd5; id_uses_rs2 = 1; id_rs2_addr = 5'd5;
        ref_eval(); #4;
        n_total++;
        if ({pc_stall, if_id_stall, id_ex_stall, id_ex_flush, ex_mem_bubble, stall_cycles} !== {5'b11010, 16'd0})
            $display("FAIL load_use_stall: got %b cnt=%0d expected 11010 cnt=0",
                     {pc_stall, if_id_stall, id_ex_stall, id_ex_flush, ex_mem_bubble}, stall_cycles);
        else n_pass++;
        advance();
        idle_inputs(); ref_eval(); #4;
        n_total++;
        if ({pc_stall, if_id_stall, id_ex_flush, stall_cycles} !== {3'b000, 16'd1})
            $display("FAIL load_use_release: got %b cnt=%0d expected 000 cnt=1",
                     {pc_stall, if_id_stall, id_ex_flush}, stall_cycles);
        else n_pass++;
        advance();
    endtask

    task automatic test_multicycle();
        for (int c = 0; c <= 5; c++) begin
            idle_inputs();
            ex_mc_start = (c == 0);
            ex_mc_done  = (c == 4);
            ref_eval(); #4;
            n_total++;
            if ({pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble, state} !==
                {{4{c < 4}}, ((c >= 1 && c <= 4) ? 2'd1 : 2'd0)})
                $display("FAIL multicycle_c%0d: got %b expected stalls=%0d state=%0d",
                         c, {pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble, state},
                         c < 4, (c >= 1 && c <= 4));
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_timeout_done_wins();
        for (int c = 0; c <= 5; c++) begin
            idle_inputs();
            ex_mc_start = (c == 0);
            ex_mc_done  = (c == TO);
            ref_eval(); #4;
            if (c == TO) begin
                n_total++;
                if ({mc_timeout, id_ex_flush, pc_stall, state} !== {3'b000, 2'd1})
                    $display("FAIL timeout_done_wins: got %b expected 00001",
                             {mc_timeout, id_ex_flush, pc_stall, state});
                else n_pass++;
            end
            if (c == 5) begin
                n_total++;
                if ({mc_timeout, state} !== 3'b000)
                    $display("FAIL timeout_done_flag: got %b expected 000", {mc_timeout, state});
                else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_timeout();
        for (int c = 0; c <= TO + 1; c++) begin
            idle_inputs();
            ex_mc_start = (c == 0);
            ref_eval(); #4;
            if (c == TO) begin
                n_total++;
                if ({mc_timeout, id_ex_flush, pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble} !== 6'b110000)
                    $display("FAIL timeout_abort: got %b expected 110000",
                             {mc_timeout, id_ex_flush, pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble});
                else n_pass++;
            end
            if (c == TO + 1) begin
                n_total++;
                if ({mc_timeout, state} !== 3'b100)
                    $display("FAIL timeout_return: got %b expected 100", {mc_timeout, state});
                else n_pass++;
            end
            advance();
        end
        clear_counters();
        ref_eval(); #4;
        n_total++;
        if ({mc_timeout, stall_cycles} !== {1'b1, 16'd0})
            $display("FAIL timeout_survives_clr: got flag=%b cnt=%0d expected 1/0", mc_timeout, stall_cycles);
        else n_pass++;
        advance();
    endtask

    task automatic test_redirect();
        clear_counters();
        for (int c = 0; c <= 3; c++) begin
            idle_inputs();
            ex_redirect = (c == 0);
            ex_mc_start = (c == 0);
            ref_eval(); #4;
            n_total++;
            if ({if_id_flush, id_ex_flush, pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble} !==
                {(c <= RB), (c == 0), 4'b0000})
                $display("FAIL redirect_c%0d: got %b expected iff=%0d idf=%0d no stalls", c,
                         {if_id_flush, id_ex_flush, pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble},
                         c <= RB, c == 0);
            else n_pass++;
            advance();
        end
        n_total++;
        if ({state, redirect_count} !== {2'd0, 16'd1})
            $display("FAIL redirect_count: got state=%0d cnt=%0d expected 0/1", state, redirect_count);
        else n_pass++;
    endtask

    task automatic test_rd_zero();
        idle_inputs();
        ex_mem_read_en = 1; ex_rd_addr = 0; id_uses_rs1 = 1; id_uses_rs2 = 1;
        ref_eval(); #4;
        n_total++;
        if ({pc_stall, if_id_stall, id_ex_flush} !== 3'b000)
            $display("FAIL rd_zero_no_stall: got %b expected 000", {pc_stall, if_id_stall, id_ex_flush});
        else n_pass++;
        advance();
    endtask

    task automatic test_random();
        logic [8:0]  got_o, exp_o;
        logic [31:0] got_c, exp_c;
        for (int i = 0; i < 3000; i++) begin
            id_rs1_addr    = 5'($urandom_range(0, 3));
            id_rs2_addr    = 5'($urandom_range(0, 3));
            ex_rd_addr     = 5'($urandom_range(0, 3));
            id_uses_rs1    = 1'($urandom);
            id_uses_rs2    = 1'($urandom);
            ex_mem_read_en = 1'($urandom);
            ex_redirect    = ($urandom_range(0, 7) == 0);
            ex_mc_start    = ($urandom_range(0, 5) == 0);
            ex_mc_done     = ($urandom_range(0, 3) == 0);
            cnt_clr        = ($urandom_range(0, 49) == 0);
            ref_eval(); #4;
            got_o = {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble, state, mc_timeout};
            exp_o = {e_pc, e_ifs, e_ids, e_iff, e_idf, e_bub, 2'(m_mode), e_to};
            n_total++;
            if (got_o !== exp_o) $display("FAIL random_outputs@%0d: got %b expected %b", i, got_o, exp_o);
            else n_pass++;
            got_c = {stall_cycles, redirect_count};
            exp_c = {16'(m_stalls), 16'(m_redirs)};
            n_total++;
            if (got_c !== exp_c) $display("FAIL random_counters@%0d: got %h expected %h", i, got_c, exp_c);
            else n_pass++;
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        ex_mem_read_en = 1; ex_rd_addr = 5'd7; id_uses_rs1 = 1; id_rs1_addr = 5'd7;
        for (int i = 0; i < 65535; i++) begin
            ref_eval(); advance();
        end
        ref_eval(); #4;
        n_total++;
        if (stall_cycles !== 16'hFFFF)
            $display("FAIL stall_reach_max: got %h expected ffff", stall_cycles);
        else n_pass++;
        advance();
        ref_eval(); #4;
        n_total++;
        if ({pc_stall, stall_cycles} !== {1'b1, 16'hFFFF})
            $display("FAIL stall_saturate: got pc=%b cnt=%h expected 1/ffff", pc_stall, stall_cycles);
        else n_pass++;
        advance();
        idle_inputs();
    endtask

    task automatic test_rst_mid_wait();
        idle_inputs(); ex_mc_start = 1;
        ref_eval(); advance();
        ex_mc_start = 0;
        ref_eval(); advance();
        #1;
        rst = 1;
        ex_mem_read_en = 1; ex_rd_addr = 5'd2; id_uses_rs1 = 1; id_rs1_addr = 5'd2;
        #1;
        n_total++;
        if ({pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble, state, mc_timeout,
             stall_cycles, redirect_count} !== 41'd0)
            $display("FAIL rst_mid_wait: got %b cnt=%h/%h expected all 0",
                     {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble, state, mc_timeout},
                     stall_cycles, redirect_count);
        else n_pass++;
        idle_inputs();
        @(posedge clk); #1;
        rst = 0;
        ref_reset();
        ex_mc_start = 1;
        ref_eval(); #4;
        n_total++;
        if ({pc_stall, ex_mem_bubble, state} !== 4'b1100)
            $display("FAIL run_after_rst: got %b expected 1100", {pc_stall, ex_mem_bubble, state});
        else n_pass++;
        advance();
        idle_inputs();
    endtask

    initial begin
        ref_reset();
        test_reset();
        test_load_use();
        test_multicycle();
        test_timeout_done_wins();
        test_timeout();
        test_redirect();
        test_rd_zero();
        test_random();
        test_saturation();
        test_rst_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
